// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared word type and fetch-stage types
//
// cpu_types_pkg : word_t, the datapath word.
// aww_types_pkg : fetch_state_t (2-bit FSM encoding) and ifid_t (IF/ID latch contents).
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

package aww_types_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    FETCH         = 2'b00,
    REDIRECT_WAIT = 2'b01,
    HALTED        = 2'b10
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t npc;
  } ifid_t;

  localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic word_t word_align(input word_t a);
    return a & WORD_ALIGN_MASK;
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus to hazard unit, branch resolution and icache
//
// Modport fetch : the fetch stage side (control and memory response in, request and IF/ID out).
// Modport ctrl  : the surrounding pipeline / memory side (mirror of fetch).
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  pc_WEN;
  logic  ifid_STALL;
  logic  ifid_FLUSH;
  logic  redirect_EN;
  word_t redirect_PC;
  logic  halt_SEEN;
  logic  dpif_ihit;
  word_t imemload;
  logic  imemREN;
  word_t imemaddr;
  logic  ifid_valid;
  word_t ifid_instr;
  word_t ifid_npc;
  logic  fetch_halted;

  modport fetch (
    input  pc_WEN, ifid_STALL, ifid_FLUSH, redirect_EN, redirect_PC,
    input  halt_SEEN, dpif_ihit, imemload,
    output imemREN, imemaddr, ifid_valid, ifid_instr, ifid_npc, fetch_halted
  );

  modport ctrl (
    output pc_WEN, ifid_STALL, ifid_FLUSH, redirect_EN, redirect_PC,
    output halt_SEEN, dpif_ihit, imemload,
    input  imemREN, imemaddr, ifid_valid, ifid_instr, ifid_npc, fetch_halted
  );
endinterface

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - pipeline latch with flush > stall > load > bubble priority
//
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset (clears to bubble)
//   i_flush      : load a bubble
//   i_stall      : hold current contents
//   i_load       : capture i_d
//   i_d / o_q    : latch input / registered contents
// With none of flush/stall/load asserted the latch takes a bubble.
module ifid_reg
  import aww_types_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_flush,
  input  logic  i_stall,
  input  logic  i_load,
  input  ifid_t i_d,
  output ifid_t o_q
);
  localparam ifid_t BUBBLE = '0;

  ifid_t r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= BUBBLE;
    end else if (i_flush) begin
      r_q <= BUBBLE;
    end else if (i_stall) begin
      r_q <= r_q;
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= BUBBLE;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, icache request, redirect and halt handling
//
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : fetch_stage_if.fetch
//     in : pc_WEN, ifid_STALL, ifid_FLUSH, redirect_EN, redirect_PC, halt_SEEN,
//          dpif_ihit, imemload
//     out: imemREN, imemaddr (word aligned), ifid_valid/instr/npc, fetch_halted
// Parameter PC_INIT: PC after reset.
module fetch_stage
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic      CLK,
  input  logic      RST,
  fetch_stage_if.fetch bus
);
  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  word_t        r_pc;
  word_t        r_redir_q;

  logic  w_adv;
  word_t w_pc_plus4;
  word_t w_redir_tgt;
  logic  w_ifid_load;
  ifid_t w_ifid_d;
  ifid_t w_ifid_q;

  assign w_adv       = bus.dpif_ihit & bus.pc_WEN;
  assign w_pc_plus4  = r_pc + 32'd4;  // wraps modulo 2^32
  assign w_redir_tgt = word_align(bus.redirect_PC);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    if (bus.halt_SEEN || r_state == HALTED) begin
      w_state_nxt = HALTED;  // sticky; only RST leaves
    end else begin
      case (r_state)
        FETCH:         if (bus.redirect_EN && !w_adv) w_state_nxt = REDIRECT_WAIT;
        REDIRECT_WAIT: if (w_adv)                     w_state_nxt = FETCH;
        default:       w_state_nxt = HALTED;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // Request depends on state and RST only, so no input reaches it combinationally.
  always_comb begin
    bus.imemREN      = 1'b0;
    bus.fetch_halted = 1'b0;
    case (r_state)
      FETCH, REDIRECT_WAIT: bus.imemREN      = !RST;
      HALTED:               bus.fetch_halted = 1'b1;
      default:              bus.imemREN      = 1'b0;
    endcase
  end

  assign bus.imemaddr = word_align(r_pc);

  // ---------------- PC and pending redirect ----------------
  // In REDIRECT_WAIT the outstanding read at the old PC must complete before
  // the target is taken; a redirect arriving on the completing cycle itself
  // is younger than redir_q and wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc      <= word_align(PC_INIT);
      r_redir_q <= '0;
    end else if (!bus.halt_SEEN && r_state != HALTED) begin
      case (r_state)
        FETCH: begin
          if (bus.redirect_EN && w_adv)  r_pc      <= w_redir_tgt;
          else if (bus.redirect_EN)      r_redir_q <= w_redir_tgt;
          else if (w_adv)                r_pc      <= w_pc_plus4;
        end
        REDIRECT_WAIT: begin
          if (w_adv)                r_pc      <= bus.redirect_EN ? w_redir_tgt : r_redir_q;
          else if (bus.redirect_EN) r_redir_q <= w_redir_tgt;
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  // ---------------- IF/ID latch ----------------
  // Only a correct-path hit in FETCH loads; wrong-path and halt cycles bubble.
  assign w_ifid_load    = (r_state == FETCH) & w_adv & !bus.redirect_EN & !bus.halt_SEEN;
  assign w_ifid_d.valid = 1'b1;
  assign w_ifid_d.instr = bus.imemload;
  assign w_ifid_d.npc   = w_pc_plus4;

  ifid_reg u_ifid_reg (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_flush (bus.ifid_FLUSH),
    .i_stall (bus.ifid_STALL),
    .i_load  (w_ifid_load),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign bus.ifid_valid = w_ifid_q.valid;
  assign bus.ifid_instr = w_ifid_q.instr;
  assign bus.ifid_npc   = w_ifid_q.npc;
endmodule
